// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for a five-stage MIPS pipeline.
// Issues word fetches over a ready handshake, applies branch/jump redirects,
// absorbs hazard stalls and presents instr / PC+4 / valid to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_INIT   = RESET_PC & WORD_MASK;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_BUF  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_buf;
    logic [XLEN-1:0] r_redir_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc4;
    logic            r_valid;
    logic            r_req;

    state_t          w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_buf_nxt;
    logic [XLEN-1:0] w_redir_pc_nxt;
    logic [XLEN-1:0] w_instr_nxt;
    logic [XLEN-1:0] w_pc4_nxt;
    logic            w_valid_nxt;
    logic            w_req_nxt;

    logic            w_redir;
    logic [XLEN-1:0] w_target_raw;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_plus4;

    // Redirect select: branch wins over jump; targets are word aligned.
    always_comb begin
        w_redir      = branch_taken | jump;
        w_target_raw = branch_taken ? branch_target : jump_target;
        w_target     = w_target_raw & WORD_MASK;
        w_pc_plus4   = r_pc + XLEN'(4);
    end

    // Next-state and IF/ID update logic; everything holds unless a rule fires.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_buf_nxt      = r_buf;
        w_redir_pc_nxt = r_redir_pc;
        w_instr_nxt    = r_instr;
        w_pc4_nxt      = r_pc4;
        w_valid_nxt    = r_valid;

        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (w_redir) begin
                    w_valid_nxt = 1'b0;
                    if (imem_ready) begin
                        w_pc_nxt = w_target;
                    end else begin
                        // address must stay stable until the pending transfer completes
                        w_redir_pc_nxt = w_target;
                        w_state_nxt    = S_DROP;
                    end
                end else if (imem_ready) begin
                    if (stall) begin
                        w_buf_nxt   = imem_rdata;
                        w_state_nxt = S_BUF;
                    end else begin
                        w_instr_nxt = imem_rdata;
                        w_pc4_nxt   = w_pc_plus4;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = w_pc_plus4;
                    end
                end else if (!stall) begin
                    w_valid_nxt = 1'b0;
                end
            end
            S_BUF: begin
                if (w_redir) begin
                    w_pc_nxt    = w_target;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_REQ;
                end else if (!stall) begin
                    w_instr_nxt = r_buf;
                    w_pc4_nxt   = w_pc_plus4;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                w_valid_nxt = 1'b0;
                if (w_redir) begin
                    w_redir_pc_nxt = w_target;
                end
                if (imem_ready) begin
                    w_pc_nxt    = w_redir ? w_target : r_redir_pc;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase

        w_req_nxt = (w_state_nxt == S_REQ) || (w_state_nxt == S_DROP);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= PC_INIT;
            r_buf      <= '0;
            r_redir_pc <= '0;
            r_instr    <= '0;
            r_pc4      <= '0;
            r_valid    <= 1'b0;
            r_req      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_buf      <= w_buf_nxt;
            r_redir_pc <= w_redir_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_pc4      <= w_pc4_nxt;
            r_valid    <= w_valid_nxt;
            r_req      <= w_req_nxt;
        end
    end

    assign imem_addr   = r_pc;
    assign imem_req    = r_req;
    assign if_id_instr = r_instr;
    assign if_id_pc4   = r_pc4;
    assign if_id_valid = r_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: address-tagged memory, transaction-level reference model,
// per-cycle compare plus hand-computed literal expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr, imem_rdata;
    logic        imem_req, imem_ready;
    logic        stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid;

    logic [31:0] addr2, rdata2, instr2, pc4_2;
    logic        req2, valid2;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = tag(imem_addr);
    assign rdata2     = tag(addr2);

    fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(addr2), .imem_req(req2),
        .imem_rdata(rdata2), .imem_ready(1'b1),
        .stall(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
        .jump(1'b0), .jump_target(32'h0),
        .if_id_instr(instr2), .if_id_pc4(pc4_2), .if_id_valid(valid2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the outstanding fetch and its fate at transaction level.
    typedef struct packed {
        logic        boot;    // first cycle after reset: no fetch issued yet
        logic        parked;  // fetched word waiting out a stall, no fetch in flight
        logic        squash;  // in-flight fetch must be thrown away
        logic [31:0] pc;      // address of the current/next fetch
        logic [31:0] sq_tgt;  // where to go once the squashed fetch finishes
        logic [31:0] park;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } model_t;

    localparam model_t M_RESET = '{boot: 1'b1, parked: 1'b0, squash: 1'b0,
                                   pc: 32'h0000_3000, sq_tgt: 32'h0, park: 32'h0,
                                   instr: 32'h0, pc4: 32'h0, valid: 1'b0};

    model_t m;

    function automatic model_t model_next(input model_t s, input logic rdy, input logic st,
                                          input logic bt, input logic [31:0] btg,
                                          input logic jp, input logic [31:0] jtg);
        model_t n = s;
        logic redir = bt | jp;
        logic [31:0] tgt = (bt ? btg : jtg) & 32'hFFFF_FFFC;
        if (s.boot) begin
            n.boot = 1'b0;
        end else if (s.parked) begin
            if (redir) begin
                n.parked = 1'b0; n.pc = tgt; n.valid = 1'b0;
            end else if (!st) begin
                n.parked = 1'b0; n.instr = s.park; n.pc4 = s.pc + 32'd4;
                n.valid = 1'b1;  n.pc = s.pc + 32'd4;
            end
        end else if (s.squash) begin
            n.valid = 1'b0;
            if (redir) n.sq_tgt = tgt;
            if (rdy) begin
                n.squash = 1'b0; n.pc = redir ? tgt : s.sq_tgt;
            end
        end else begin
            if (redir) begin
                n.valid = 1'b0;
                if (rdy) n.pc = tgt;
                else begin n.squash = 1'b1; n.sq_tgt = tgt; end
            end else if (rdy) begin
                if (st) begin
                    n.parked = 1'b1; n.park = tag(s.pc);
                end else begin
                    n.instr = tag(s.pc); n.pc4 = s.pc + 32'd4;
                    n.valid = 1'b1;      n.pc = s.pc + 32'd4;
                end
            end else if (!st) begin
                n.valid = 1'b0;
            end
        end
        return n;
    endfunction

    // Model advances on the same edge as the DUT and resets asynchronously with it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= M_RESET;
        else        m <= model_next(m, imem_ready, stall, branch_taken, branch_target,
                                    jump, jump_target);
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("imem_req",    32'(imem_req),    32'(!m.boot && !m.parked));
            check("imem_addr",   imem_addr,        m.pc);
            check("if_id_valid", 32'(if_id_valid), 32'(m.valid));
            check("if_id_instr", if_id_instr,      m.instr);
            check("if_id_pc4",   if_id_pc4,        m.pc4);
        end
    end

    task automatic cyc(input logic rdy, input logic st, input logic bt, input logic [31:0] btg,
                       input logic jp, input logic [31:0] jtg);
        @(negedge clk);
        imem_ready = rdy; stall = st; branch_taken = bt; branch_target = btg;
        jump = jp; jump_target = jtg;
    endtask

    initial begin
        rst_n = 1'b0;
        imem_ready = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        // c0: BOOT
        check("c0 req",   32'(imem_req), 32'h0);
        check("c0 addr",  imem_addr,     32'h0000_3000);
        check("c0 valid", 32'(if_id_valid), 32'h0);
        chk_en = 1'b1;

        cyc(1, 0, 0, 0, 0, 0);                          // c1
        check("c1 req",  32'(imem_req), 32'h1);
        check("c1 addr", imem_addr, 32'h0000_3000);
        check("wrap c1 addr", addr2, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0, 0);                          // c2: wait on 0x3004
        check("c2 valid", 32'(if_id_valid), 32'h1);
        check("c2 instr", if_id_instr, 32'hC0DE_3000);
        check("c2 pc4",   if_id_pc4,   32'h0000_3004);
        check("wrap c2 addr",  addr2,  32'h0000_0000);
        check("wrap c2 pc4",   pc4_2,  32'h0000_0000);
        check("wrap c2 instr", instr2, 32'h3F21_FFFC);
        cyc(0, 0, 0, 0, 0, 0);                          // c3
        check("c3 bubble", 32'(if_id_valid), 32'h0);
        cyc(1, 0, 0, 0, 0, 0);                          // c4
        check("c4 bubble", 32'(if_id_valid), 32'h0);
        check("c4 addr held", imem_addr, 32'h0000_3004);
        cyc(1, 1, 0, 0, 0, 0);                          // c5: stall on completing 0x3008
        check("c5 instr", if_id_instr, 32'hC0DE_3004);
        check("c5 pc4",   if_id_pc4,   32'h0000_3008);
        cyc(1, 1, 0, 0, 0, 0);                          // c6: BUF
        check("c6 req", 32'(imem_req), 32'h0);
        cyc(1, 1, 0, 0, 0, 0);                          // c7
        cyc(1, 0, 0, 0, 0, 0);                          // c8: release
        check("c8 frozen", if_id_instr, 32'hC0DE_3004);
        cyc(0, 0, 0, 0, 1, 32'h0000_4000);              // c9: jump while 0x300C pending
        check("c9 instr", if_id_instr, 32'hC0DE_3008);
        check("c9 pc4",   if_id_pc4,   32'h0000_300C);
        check("c9 addr",  imem_addr,   32'h0000_300C);
        cyc(0, 0, 1, 32'h0000_5000, 0, 0);              // c10: DROP, branch overrides
        check("c10 addr", imem_addr, 32'h0000_300C);
        check("c10 valid", 32'(if_id_valid), 32'h0);
        cyc(1, 0, 0, 0, 0, 0);                          // c11
        cyc(1, 0, 0, 0, 0, 0);                          // c12
        check("c12 addr", imem_addr, 32'h0000_5000);
        cyc(1, 1, 1, 32'h0000_6000, 1, 32'h0000_7000);  // c13: all at once
        check("c13 instr", if_id_instr, 32'hC0DE_5000);
        cyc(1, 0, 0, 0, 0, 0);                          // c14
        check("c14 addr",  imem_addr, 32'h0000_6000);
        check("c14 valid", 32'(if_id_valid), 32'h0);
        cyc(1, 1, 0, 0, 0, 0);                          // c15
        cyc(1, 0, 0, 0, 1, 32'h0000_8003);              // c16: redirect out of BUF
        check("c16 req", 32'(imem_req), 32'h0);
        cyc(0, 1, 0, 0, 0, 0);                          // c17
        check("c17 addr", imem_addr, 32'h0000_8000);
        cyc(0, 0, 0, 0, 0, 0);                          // c18
        cyc(1, 0, 0, 0, 0, 0);                          // c19
        cyc(1, 0, 0, 0, 0, 0);                          // c20
        check("c20 instr", if_id_instr, 32'hC0DE_8000);
        check("c20 pc4",   if_id_pc4,   32'h0000_8004);

        // Mixed random traffic, checked entirely by the model.
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 9) == 0), $urandom,
                1'($urandom_range(0, 9) == 0), $urandom);
        end
        cyc(1, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst req",   32'(imem_req),    32'h0);
        check("arst addr",  imem_addr,        32'h0000_3000);
        check("arst valid", 32'(if_id_valid), 32'h0);
        check("arst instr", if_id_instr,      32'h0);
        check("arst pc4",   if_id_pc4,        32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("post-reset instr", if_id_instr, 32'hC0DE_3000);
        repeat (3) cyc(1, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
